// File: rtl/pgm_pkg.sv
// rtl/pgm_pkg.sv - shared constants, loader state type and lane helper for the PGM ROM loader
package pgm_pkg;

   localparam logic [28:0] DDR_ROM_BASE   = 29'h0600_0000;
   localparam logic [7:0]  ROM_INDEX_PROG = 8'd0;

   typedef enum logic [1:0] {
      LDR_IDLE,
      LDR_LOAD,
      LDR_FLUSH,
      LDR_DRAIN
   } t_ldr_state;

   // Two byte enables per 16-bit lane, lane 0 in the low bytes.
   function automatic logic [7:0] lane_to_be(input logic [1:0] lane);
      return 8'b0000_0011 << {lane, 1'b0};
   endfunction

endpackage

// File: rtl/pgm_rom_loader.sv
// rtl/pgm_rom_loader.sv - packs ioctl halfwords into 64-bit DDRAM writes with a pack slot and an out slot
module pgm_rom_loader
   import pgm_pkg::*;
#(
   parameter logic [28:0] DDR_BASE  = DDR_ROM_BASE,
   parameter logic [7:0]  ROM_INDEX = ROM_INDEX_PROG,
   parameter logic        BYTE_SWAP = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        ioctl_wait,
   output logic [28:0] ddram_addr,
   output logic [3:0]  ddram_burstcnt,
   output logic [63:0] ddram_din,
   output logic [7:0]  ddram_be,
   output logic        ddram_we,
   input  logic        ddram_busy,
   output logic [23:0] wr_count,
   output logic        load_done
);

   t_ldr_state  state_q, state_d;
   logic        pack_valid_q, pack_valid_d;
   logic [23:0] pack_waddr_q, pack_waddr_d;
   logic [63:0] pack_din_q, pack_din_d;
   logic [7:0]  pack_be_q, pack_be_d;
   logic        out_valid_q, out_valid_d;
   logic [28:0] out_addr_q, out_addr_d;
   logic [63:0] out_din_q, out_din_d;
   logic [7:0]  out_be_q, out_be_d;
   logic [23:0] wr_count_q, wr_count_d;
   logic        load_done_q, load_done_d;

   logic [1:0]  lane;
   logic [23:0] waddr_in;
   logic [15:0] half;
   logic [63:0] lane_din;
   logic [63:0] lane_mask;
   logic [7:0]  lane_be;
   logic [63:0] merge_din;
   logic [7:0]  merge_be;
   logic        wr_accept;
   logic        out_accept;
   logic        out_free;
   logic        move;
   logic [23:0] move_waddr;
   logic [63:0] move_din;
   logic [7:0]  move_be;

   // Halfwords are always aligned, so address bit 0 carries no information.
   logic        unused_addr0;
   assign unused_addr0 = ioctl_addr[0];

   assign ioctl_wait     = out_valid_q & pack_valid_q;
   assign ddram_addr     = out_addr_q;
   assign ddram_burstcnt = 4'd1;
   assign ddram_din      = out_din_q;
   assign ddram_be       = out_be_q;
   assign ddram_we       = out_valid_q;
   assign wr_count       = wr_count_q;
   assign load_done      = load_done_q;

   always_comb begin
      lane      = ioctl_addr[2:1];
      waddr_in  = ioctl_addr[26:3];
      half      = BYTE_SWAP ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;
      lane_be   = lane_to_be(lane);
      lane_din  = {48'd0, half} << {lane, 4'b0000};
      lane_mask = 64'h0000_0000_0000_FFFF << {lane, 4'b0000};
      merge_be  = pack_be_q | lane_be;
      merge_din = (pack_din_q & ~lane_mask) | lane_din;

      // New data is only taken while a window is open and not being closed out.
      wr_accept  = ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX) & ~ioctl_wait &
                   ((state_q == LDR_IDLE) | (state_q == LDR_LOAD));
      out_accept = out_valid_q & ~ddram_busy;
      out_free   = ~out_valid_q | out_accept;

      pack_valid_d = pack_valid_q;
      pack_waddr_d = pack_waddr_q;
      pack_din_d   = pack_din_q;
      pack_be_d    = pack_be_q;
      out_valid_d  = out_valid_q & ~out_accept;
      out_addr_d   = out_addr_q;
      out_din_d    = out_din_q;
      out_be_d     = out_be_q;
      move         = 1'b0;
      move_waddr   = pack_waddr_q;
      move_din     = pack_din_q;
      move_be      = pack_be_q;

      if (wr_accept) begin
         if (!pack_valid_q) begin
            pack_valid_d = 1'b1;
            pack_waddr_d = waddr_in;
            pack_din_d   = lane_din;
            pack_be_d    = lane_be;
         end else if (pack_waddr_q == waddr_in) begin
            if (merge_be == 8'hFF) begin
               move         = 1'b1;
               move_din     = merge_din;
               move_be      = merge_be;
               pack_valid_d = 1'b0;
            end else begin
               pack_din_d = merge_din;
               pack_be_d  = merge_be;
            end
         end else begin
            move         = 1'b1;
            pack_waddr_d = waddr_in;
            pack_din_d   = lane_din;
            pack_be_d    = lane_be;
         end
      end else if ((state_q == LDR_FLUSH) && pack_valid_q && out_free) begin
         move         = 1'b1;
         pack_valid_d = 1'b0;
      end

      if (move) begin
         out_valid_d = 1'b1;
         out_addr_d  = DDR_BASE + {5'd0, move_waddr};
         out_din_d   = move_din;
         out_be_d    = move_be;
      end

      state_d     = state_q;
      load_done_d = 1'b0;
      wr_count_d  = wr_count_q;
      if (out_accept && (wr_count_q != 24'hFF_FFFF)) begin
         wr_count_d = wr_count_q + 24'd1;
      end

      case (state_q)
         LDR_IDLE: begin
            if (ioctl_download) begin
               state_d    = LDR_LOAD;
               wr_count_d = 24'd0;
            end
         end
         LDR_LOAD: begin
            if (!ioctl_download) begin
               state_d = pack_valid_q ? LDR_FLUSH : LDR_DRAIN;
            end
         end
         LDR_FLUSH: begin
            if (!pack_valid_q || out_free) begin
               state_d = LDR_DRAIN;
            end
         end
         LDR_DRAIN: begin
            // A re-opened window suppresses the completion pulse of the old one.
            if (!out_valid_q) begin
               if (ioctl_download) begin
                  state_d    = LDR_LOAD;
                  wr_count_d = 24'd0;
               end else begin
                  state_d     = LDR_IDLE;
                  load_done_d = 1'b1;
               end
            end
         end
         default: state_d = LDR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= LDR_IDLE;
         pack_valid_q <= 1'b0;
         pack_waddr_q <= 24'd0;
         pack_din_q   <= 64'd0;
         pack_be_q    <= 8'd0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= 29'd0;
         out_din_q    <= 64'd0;
         out_be_q     <= 8'd0;
         wr_count_q   <= 24'd0;
         load_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pack_valid_q <= pack_valid_d;
         pack_waddr_q <= pack_waddr_d;
         pack_din_q   <= pack_din_d;
         pack_be_q    <= pack_be_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         out_din_q    <= out_din_d;
         out_be_q     <= out_be_d;
         wr_count_q   <= wr_count_d;
         load_done_q  <= load_done_d;
      end
   end

endmodule
